// File: rtl/mac_sched.sv
// Round-robin scheduler sharing one dot-product MAC between two requesters.
// Optional MAC_TIMEOUT_EN aborts a stuck WAIT after TIMEOUT_CYC cycles.
module mac_sched #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic [1:0]        r0_mode,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [DATA_W-1:0] r0_c,
  input  logic [DATA_W-1:0] r0_d,
  output logic              r0_gnt,
  input  logic              r1_req,
  input  logic [1:0]        r1_mode,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [DATA_W-1:0] r1_c,
  input  logic [DATA_W-1:0] r1_d,
  output logic              r1_gnt,
  output logic [1:0]        done,
  output logic              err,
  output logic [DATA_W-1:0] res,
  output logic              busy,
  output logic [3:0]        mac_ctrl,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic [DATA_W-1:0] mac_c,
  output logic [DATA_W-1:0] mac_d,
  input  logic [1:0]        mac_status,
  input  logic [DATA_W-1:0] mac_ketqua,
  output logic [2:0]        o_dbg_state
);

  // Handshake: a requester holds req (operands stable) until its one-cycle gnt;
  // gnt marks the clock edge on which operands are captured. done is a
  // one-cycle pulse to the owner with err/res valid in the same cycle.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            r_state, w_next;
  logic              r_rr_ptr, r_owner, r_err;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_res, r_a, r_b, r_c, r_d;
  logic              w_arb_en, w_gnt0, w_gnt1, w_grant, w_reserved;
  logic [1:0]        w_sel_mode;
  logic              w_timeout, w_mac_rst_pulse;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  // Under contention the requester that was not granted last wins.
  assign w_arb_en   = rst_n && (r_state == S_IDLE);
  assign w_gnt0     = w_arb_en && r0_req && (!r1_req || r_rr_ptr);
  assign w_gnt1     = w_arb_en && r1_req && (!r0_req || !r_rr_ptr);
  assign w_grant    = w_gnt0 || w_gnt1;
  assign w_sel_mode = w_gnt1 ? r1_mode : r0_mode;
  assign w_reserved = (w_sel_mode == 2'b10);

`ifdef MAC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_to_rst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_to_rst   <= 1'b0;
    end else begin
      r_to_rst <= w_timeout;
      if (r_state == S_ISSUE)
        r_wait_cnt <= '0;
      else if (r_state == S_WAIT)
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  assign w_timeout       = (r_state == S_WAIT) && (mac_status != 2'b11) &&
                           (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_mac_rst_pulse = r_to_rst;
`else
  assign w_timeout       = 1'b0;
  assign w_mac_rst_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= 1'b0;
      r_owner  <= 1'b0;
      r_err    <= 1'b0;
      r_mode   <= 2'b00;
      r_res    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_owner  <= w_gnt1;
        r_rr_ptr <= w_gnt1;
        r_mode   <= w_sel_mode;
        r_a      <= w_gnt1 ? r1_a : r0_a;
        r_b      <= w_gnt1 ? r1_b : r0_b;
        r_c      <= w_gnt1 ? r1_c : r0_c;
        r_d      <= w_gnt1 ? r1_d : r0_d;
        r_err    <= w_reserved;
        if (w_reserved)
          r_res <= '0;
      end else if (r_state == S_WAIT) begin
        // res only changes on entry to RESP, so it holds between done pulses.
        if (mac_status == 2'b11) begin
          r_res <= mac_ketqua;
        end else if (w_timeout) begin
          r_res <= '0;
          r_err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    mac_ctrl = 4'b0000;
    case (r_state)
      S_IDLE: begin
        mac_ctrl = 4'b0100;
        if (w_grant)
          w_next = w_reserved ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        mac_ctrl = {2'b11, r_mode};
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        mac_ctrl = {2'b11, r_mode};
        if (mac_status == 2'b11 || w_timeout)
          w_next = S_RESP;
      end
      S_RESP: begin
        mac_ctrl = {1'b0, ~w_mac_rst_pulse, r_mode};
        w_next   = S_DRAIN;
      end
      S_DRAIN: begin
        mac_ctrl = 4'b0100;
        if (mac_status == 2'b00)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // While reset is asserted the MAC is held in its own reset.
    if (!rst_n)
      mac_ctrl = 4'b0000;
  end

  assign r0_gnt      = w_gnt0;
  assign r1_gnt      = w_gnt1;
  assign done        = (r_state == S_RESP) ? {r_owner, ~r_owner} : 2'b00;
  assign err         = (r_state == S_RESP) && r_err;
  assign res         = r_res;
  assign busy        = (r_state != S_IDLE);
  assign mac_a       = r_a;
  assign mac_b       = r_b;
  assign mac_c       = r_c;
  assign mac_d       = r_d;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mac_sched.sv
// Self-checking bench for mac_sched with a behavioural MAC and a result scoreboard.
module tb_mac_sched;
  localparam int DW = 32;

  logic          clk, rst_n;
  logic          r0_req, r1_req, r0_gnt, r1_gnt;
  logic [1:0]    r0_mode, r1_mode;
  logic [DW-1:0] r0_a, r0_b, r0_c, r0_d, r1_a, r1_b, r1_c, r1_d;
  logic [1:0]    done;
  logic          err, busy;
  logic [DW-1:0] res, mac_a, mac_b, mac_c, mac_d, mac_ketqua;
  logic [3:0]    mac_ctrl;
  logic [1:0]    mac_status;
  logic [2:0]    o_dbg_state;

  int n_vec = 0;
  int n_miss = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int mac_lat = 0;
  int mac_wait = 0;
  bit mac_stall = 0;

  logic [DW:0] exp_q0[$];
  logic [DW:0] exp_q1[$];
  logic        exp_gnt_q[$];

  mac_sched #(.DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_mode(r0_mode), .r0_a(r0_a), .r0_b(r0_b), .r0_c(r0_c), .r0_d(r0_d),
    .r0_gnt(r0_gnt),
    .r1_req(r1_req), .r1_mode(r1_mode), .r1_a(r1_a), .r1_b(r1_b), .r1_c(r1_c), .r1_d(r1_d),
    .r1_gnt(r1_gnt),
    .done(done), .err(err), .res(res), .busy(busy), .mac_ctrl(mac_ctrl),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_d(mac_d),
    .mac_status(mac_status), .mac_ketqua(mac_ketqua), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dot(input logic [1:0] m, input logic [DW-1:0] a, b, c, d);
    logic [DW-1:0] mask;
    case (m)
      2'b00:   mask = 32'h0000_000F;
      2'b01:   mask = 32'h0000_00FF;
      2'b11:   mask = 32'h0000_FFFF;
      default: mask = 32'h0;
    endcase
    return (a & mask) * (c & mask) + (b & mask) * (d & mask);
  endfunction

  // ---------------- behavioural MAC ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_status <= 2'b00;
      mac_ketqua <= '0;
      mac_wait   <= 0;
    end else if (!mac_ctrl[2]) begin
      mac_status <= 2'b00;
      mac_wait   <= 0;
    end else if (mac_ctrl[3]) begin
      if (mac_status != 2'b11 && !mac_stall) begin
        if (mac_wait >= mac_lat) begin
          mac_status <= 2'b11;
          mac_ketqua <= dot(mac_ctrl[1:0], mac_a, mac_b, mac_c, mac_d);
        end else begin
          mac_wait <= mac_wait + 1;
        end
      end
    end else begin
      mac_status <= 2'b00;
      mac_wait   <= 0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst_n) begin
      if (mac_ctrl[3]) start_cnt++;
      if (r0_gnt || r1_gnt) begin
        check_eq("gnt_onehot", r0_gnt & r1_gnt, 0);
        if (exp_gnt_q.size() == 0) check_eq("gnt_unexp", {r1_gnt, r0_gnt}, 0);
        else check_eq("gnt_id", r1_gnt, exp_gnt_q.pop_front());
      end
      if (done != 2'b00) begin
        done_cnt++;
        check_eq("done_onehot", done, done[1] ? 2'b10 : 2'b01);
        if (done[1] && exp_q1.size() != 0) begin
          e = exp_q1.pop_front();
          check_eq("r1_res", res, e[DW-1:0]);
          check_eq("r1_err", err, e[DW]);
        end else if (done[0] && !done[1] && exp_q0.size() != 0) begin
          e = exp_q0.pop_front();
          check_eq("r0_res", res, e[DW-1:0]);
          check_eq("r0_err", err, e[DW]);
        end else begin
          check_eq("done_unexp", done, 2'b00);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_job(input bit id, input logic [1:0] m, input logic [DW-1:0] a, b, c, d,
                        input bit push_gnt, input bit exp_to);
    logic [DW:0] e;
    bit got;
    e = (m == 2'b10 || exp_to) ? {1'b1, {DW{1'b0}}} : {1'b0, dot(m, a, b, c, d)};
    @(posedge clk);
    #1;
    if (push_gnt) exp_gnt_q.push_back(id);
    if (id) begin
      exp_q1.push_back(e);
      r1_mode = m; r1_a = a; r1_b = b; r1_c = c; r1_d = d; r1_req = 1'b1;
    end else begin
      exp_q0.push_back(e);
      r0_mode = m; r0_a = a; r0_b = b; r0_c = c; r0_d = d; r0_req = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = id ? r1_gnt : r0_gnt;
    end
    if (!got) check_eq(id ? "gnt_timeout_r1" : "gnt_timeout_r0", got, 1);
    @(posedge clk);
    #1;
    if (id) r1_req = 1'b0;
    else    r0_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = !busy && exp_q0.size() == 0 && exp_q1.size() == 0 && exp_gnt_q.size() == 0;
    end
    check_eq(tag, ok, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int snap;
    bit seen;
    int wcnt;
    rst_n = 1'b0;
    r0_req = 0; r1_req = 0; r0_mode = 0; r1_mode = 0;
    r0_a = 0; r0_b = 0; r0_c = 0; r0_d = 0;
    r1_a = 0; r1_b = 0; r1_c = 0; r1_d = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_gnt", {r1_gnt, r0_gnt}, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_res", res, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mac_ctrl", mac_ctrl, 4'b0000);
    check_eq("rst_mac_ops", {mac_a, mac_b, mac_c, mac_d}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_mac_ctrl", mac_ctrl, 4'b0100);

    // 1: r0 mode 00, latency profile gnt@0, done@3, IDLE@5
    do_job(0, 2'b00, 32'd3, 32'd2, 32'd4, 32'd5, 1, 0);
    repeat (3) @(negedge clk);
    check_eq("t1_done_at3", done, 2'b01);
    check_eq("t1_res", res, 32'd22);
    @(negedge clk);
    check_eq("t1_busy_at4", busy, 1);
    @(negedge clk);
    check_eq("t1_idle_at5", busy, 0);
    wait_idle("t1_idle");

    // 2: r1 mode 11 full 16-bit operands
    do_job(1, 2'b11, 32'h0000_FFFF, 32'd0, 32'h0000_FFFF, 32'd0, 1, 0);
    wait_idle("t2_idle");
    check_eq("t2_res_held", res, 32'hFFFE_0001);

    // 3: contention with pointer reset to 0 -> r1, r0, r1, r0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_gnt_q.push_back(1'b1); exp_gnt_q.push_back(1'b0);
    exp_gnt_q.push_back(1'b1); exp_gnt_q.push_back(1'b0);
    snap = done_cnt;
    fork
      begin
        do_job(0, 2'b01, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0);
        do_job(0, 2'b11, 32'h1234, 32'h5678, 32'h9ABC, 32'hDEF0, 0, 0);
      end
      begin
        do_job(1, 2'b00, 32'h7, 32'h8, 32'h9, 32'hA, 0, 0);
        do_job(1, 2'b01, 32'hF0, 32'h0F, 32'hAA, 32'h55, 0, 0);
      end
    join
    wait_idle("t3_idle");
    check_eq("t3_done_count", done_cnt - snap, 4);

    // 4: reserved mode never starts the MAC
    snap = start_cnt;
    do_job(0, 2'b10, 32'h5, 32'h6, 32'h7, 32'h8, 1, 0);
    wait_idle("t4_idle");
    check_eq("t4_no_start", start_cnt, snap);
    check_eq("t4_res_zero", res, 0);

`ifdef MAC_TIMEOUT_EN
    // 5: stuck MAC aborts after 16 WAIT cycles with a 1-cycle MAC reset
    mac_stall = 1;
    do_job(0, 2'b11, 32'h3, 32'h3, 32'h3, 32'h3, 1, 1);
    seen = 0;
    wcnt = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (o_dbg_state == 3'd2) wcnt++;
      if (done != 2'b00) begin
        seen = 1;
        check_eq("t5_mac_rst_pulse", mac_ctrl[2], 0);
      end
    end
    check_eq("t5_done_seen", seen, 1);
    check_eq("t5_wait_cycles", wcnt, 16);
    @(negedge clk);
    check_eq("t5_drain_ctrl", mac_ctrl, 4'b0100);
    wait_idle("t5_idle");
    mac_stall = 0;
`else
    // 5: without the timeout, WAIT holds for as long as the MAC stalls
    mac_stall = 1;
    snap = done_cnt;
    do_job(0, 2'b01, 32'h12, 32'h34, 32'h56, 32'h78, 1, 0);
    repeat (40) @(negedge clk);
    check_eq("t5_still_wait", o_dbg_state, 3'd2);
    check_eq("t5_no_done", done_cnt, snap);
    check_eq("t5_ctrl_held", mac_ctrl, 4'b1101);
    mac_stall = 0;
    wait_idle("t5_idle");
`endif

    // 6: reset during WAIT aborts immediately, then a fresh r1 job completes
    mac_stall = 1;
    do_job(1, 2'b11, 32'hAB, 32'hCD, 32'hEF, 32'h12, 1, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (o_dbg_state == 3'd2);
    end
    check_eq("t6_in_wait", seen, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_done", done, 0);
    check_eq("t6_err", err, 0);
    check_eq("t6_res", res, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_mac_ctrl", mac_ctrl, 4'b0000);
    check_eq("t6_mac_ops", {mac_a, mac_b, mac_c, mac_d}, 0);
    exp_q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mac_stall = 0;
    do_job(1, 2'b01, 32'h21, 32'h43, 32'h65, 32'h87, 1, 0);
    wait_idle("t6_idle");

    // random single jobs with varied MAC latency
    for (int k = 0; k < 8; k++) begin
      mac_lat = $urandom_range(0, 3);
      do_job(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             $urandom, $urandom, $urandom, $urandom, 1, 0);
      wait_idle("rand_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
